// File: rtl/eth_cfg_regs_mc_if.sv
// Avalon-MM slave bus bundle for the eth_cfg_regs_mc configuration register bank.
// Address layout: [3:0] register index, [CH_W+3:4] channel select.
interface eth_cfg_regs_mc_if #(
  parameter int CH_W = 3
);
  logic            write;
  logic            read;
  logic [CH_W+3:0] address;
  logic [31:0]     writedata;
  logic [3:0]      byteenable;
  logic [31:0]     readdata;
  logic            readdatavalid;

  modport master (
    output write, read, address, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  write, read, address, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/eth_cfg_regs_mc.sv
// Multi-channel double-buffered UDP/IP/Ethernet TX config registers (shadow -> active on commit).
// Define ETH_CFG_AUTO_CSUM_EN to compute the IP-header partial checksum in hardware on commit.
module eth_cfg_regs_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          CH_W      = 3,
  parameter logic [15:0] CSUM_BASE = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  eth_cfg_regs_mc_if.slave       bus,
  output logic [NUM_CH*16-1:0]   checksum_o,
  output logic [NUM_CH*16-1:0]   local_port_o,
  output logic [NUM_CH*16-1:0]   remote_port_o,
  output logic [NUM_CH*32-1:0]   local_ip_o,
  output logic [NUM_CH*32-1:0]   remote_ip_o,
  output logic [NUM_CH*48-1:0]   local_mac_o,
  output logic [NUM_CH*48-1:0]   remote_mac_o,
  output logic [NUM_CH-1:0]      cfg_update_o,
  output logic [NUM_CH-1:0]      busy_o
);

  function automatic logic [31:0] rst_val(input int i);
    case (i)
      0:       return 32'h0000_F957;
      1:       return 32'h0000_AAAA;
      2:       return 32'h0000_FDE2;
      3:       return 32'hC0A8_0004;
      4:       return 32'hC0A8_0005;
      5:       return 32'h3A85_1BD7;
      6:       return 32'h0000_74EA;
      7:       return 32'hFFFF_FFFF;
      8:       return 32'h0000_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [3:0]      idx;
  logic [CH_W-1:0] ch;
  assign idx = bus.address[3:0];
  assign ch  = bus.address[CH_W+3:4];

  logic [31:0]       shadow [NUM_CH][9];
  logic [31:0]       rd_val;
  logic [31:0]       readdata_q;
  logic              rdv_q;
  logic [NUM_CH-1:0] commit_req;
  logic [NUM_CH-1:0] status_rd;
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] err_q;

  logic [NUM_CH-1:0] load_en;
  logic [15:0]       load_csum [NUM_CH];
  logic [31:0]       load_src  [NUM_CH][9];

  logic [15:0] act_csum  [NUM_CH];
  logic [15:0] act_lport [NUM_CH];
  logic [15:0] act_rport [NUM_CH];
  logic [31:0] act_lip   [NUM_CH];
  logic [31:0] act_rip   [NUM_CH];
  logic [47:0] act_lmac  [NUM_CH];
  logic [47:0] act_rmac  [NUM_CH];
  logic [NUM_CH-1:0] cfg_update_q;

  // Channels outside 0..NUM_CH-1 never match, so they read 0 and drop writes.
  always_comb begin
    rd_val     = '0;
    commit_req = '0;
    status_rd  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CH_W'(c)) begin
        for (int i = 0; i < 9; i++) begin
          if (idx == 4'(i)) rd_val = shadow[c][i];
        end
        if (idx == 4'd10) rd_val = {30'd0, err_q[c], busy_q[c]};
        commit_req[c] = bus.write && (idx == 4'd9) && bus.writedata[0] && bus.byteenable[0];
        status_rd[c]  = bus.read && (idx == 4'd10);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < 9; i++) shadow[c][i] <= rst_val(i);
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      rdv_q <= bus.read;
      if (bus.read) readdata_q <= rd_val;
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < 9; i++)
          if (bus.write && (ch == CH_W'(c)) && (idx == 4'(i)))
            for (int b = 0; b < 4; b++)
              if (bus.byteenable[b]) shadow[c][i][8*b +: 8] <= bus.writedata[8*b +: 8];
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdv_q;

`ifdef ETH_CFG_AUTO_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ACC0, S_ACC1, S_ACC2, S_ACC3, S_FOLD1, S_FOLD2, S_DONE
  } state_t;

  state_t      state [NUM_CH];
  logic [19:0] acc   [NUM_CH];
  logic [31:0] stage [NUM_CH][9];

  // Staging isolates the engine from shadow writes made while it runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= S_IDLE;
        acc[c]    <= '0;
        busy_q[c] <= 1'b0;
        err_q[c]  <= 1'b0;
        for (int i = 0; i < 9; i++) stage[c][i] <= rst_val(i);
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (commit_req[c] && busy_q[c]) err_q[c] <= 1'b1;
        else if (status_rd[c])          err_q[c] <= 1'b0;
        case (state[c])
          S_IDLE: if (commit_req[c]) begin
            for (int i = 0; i < 9; i++) stage[c][i] <= shadow[c][i];
            acc[c]    <= {4'd0, CSUM_BASE};
            busy_q[c] <= 1'b1;
            state[c]  <= S_ACC0;
          end
          S_ACC0: begin acc[c] <= acc[c] + {4'd0, stage[c][3][31:16]}; state[c] <= S_ACC1; end
          S_ACC1: begin acc[c] <= acc[c] + {4'd0, stage[c][3][15:0]};  state[c] <= S_ACC2; end
          S_ACC2: begin acc[c] <= acc[c] + {4'd0, stage[c][4][31:16]}; state[c] <= S_ACC3; end
          S_ACC3: begin acc[c] <= acc[c] + {4'd0, stage[c][4][15:0]};  state[c] <= S_FOLD1; end
          S_FOLD1: begin acc[c] <= {4'd0, acc[c][15:0]} + {16'd0, acc[c][19:16]}; state[c] <= S_FOLD2; end
          S_FOLD2: begin acc[c] <= {4'd0, acc[c][15:0]} + {16'd0, acc[c][19:16]}; state[c] <= S_DONE; end
          S_DONE: begin
            busy_q[c] <= 1'b0;
            state[c]  <= S_IDLE;
          end
          default: state[c] <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      load_en[c]   = (state[c] == S_DONE);
      load_csum[c] = ~acc[c][15:0];
      for (int i = 0; i < 9; i++) load_src[c][i] = stage[c][i];
    end
  end
`else
  assign busy_q  = '0;
  assign err_q   = '0;
  assign load_en = commit_req;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      load_csum[c] = shadow[c][0][15:0];
      for (int i = 0; i < 9; i++) load_src[c][i] = shadow[c][i];
    end
  end

  logic unused_no_engine;
  assign unused_no_engine = ^{status_rd, CSUM_BASE};
`endif

  // Active set only ever changes as a whole, together with the update pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_update_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        act_csum[c]  <= 16'hF957;
        act_lport[c] <= 16'hAAAA;
        act_rport[c] <= 16'hFDE2;
        act_lip[c]   <= 32'hC0A8_0004;
        act_rip[c]   <= 32'hC0A8_0005;
        act_lmac[c]  <= 48'h74EA_3A85_1BD7;
        act_rmac[c]  <= 48'hFFFF_FFFF_FFFF;
      end
    end else begin
      cfg_update_q <= load_en;
      for (int c = 0; c < NUM_CH; c++) begin
        if (load_en[c]) begin
          act_csum[c]  <= load_csum[c];
          act_lport[c] <= load_src[c][1][15:0];
          act_rport[c] <= load_src[c][2][15:0];
          act_lip[c]   <= load_src[c][3];
          act_rip[c]   <= load_src[c][4];
          act_lmac[c]  <= {load_src[c][6][15:0], load_src[c][5]};
          act_rmac[c]  <= {load_src[c][8][15:0], load_src[c][7]};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign checksum_o[16*g +: 16]    = act_csum[g];
    assign local_port_o[16*g +: 16]  = act_lport[g];
    assign remote_port_o[16*g +: 16] = act_rport[g];
    assign local_ip_o[32*g +: 32]    = act_lip[g];
    assign remote_ip_o[32*g +: 32]   = act_rip[g];
    assign local_mac_o[48*g +: 48]   = act_lmac[g];
    assign remote_mac_o[48*g +: 48]  = act_rmac[g];
  end

  assign cfg_update_o = cfg_update_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_eth_cfg_regs_mc.sv
// Self-checking bench for eth_cfg_regs_mc: vector table with a read scoreboard plus commit/reset sequences.
// Expectations follow ETH_CFG_AUTO_CSUM_EN when it is defined for the build.
module tb_eth_cfg_regs_mc;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 3;
`ifdef ETH_CFG_AUTO_CSUM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eth_cfg_regs_mc_if #(.CH_W(CH_W)) bus_if ();

  logic [NUM_CH*16-1:0] checksum_o, local_port_o, remote_port_o;
  logic [NUM_CH*32-1:0] local_ip_o, remote_ip_o;
  logic [NUM_CH*48-1:0] local_mac_o, remote_mac_o;
  logic [NUM_CH-1:0]    cfg_update_o, busy_o;

  eth_cfg_regs_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CSUM_BASE(16'h0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus_if.slave),
    .checksum_o    (checksum_o),
    .local_port_o  (local_port_o),
    .remote_port_o (remote_port_o),
    .local_ip_o    (local_ip_o),
    .remote_ip_o   (remote_ip_o),
    .local_mac_o   (local_mac_o),
    .remote_mac_o  (remote_mac_o),
    .cfg_update_o  (cfg_update_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [2:0]  ch;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic        exp_valid = 1'b0;
  int          upd_count [NUM_CH];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, bit rd, logic [2:0] ch, logic [3:0] idx,
                              logic [31:0] wdata, logic [3:0] be, logic [31:0] exp_rd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.ch = ch; v.idx = idx;
    v.wdata = wdata; v.be = be; v.exp_rd = exp_rd;
    return v;
  endfunction

  function automatic logic [31:0] rst_reg(int i);
    case (i)
      0: return 32'h0000_F957;
      1: return 32'h0000_AAAA;
      2: return 32'h0000_FDE2;
      3: return 32'hC0A8_0004;
      4: return 32'hC0A8_0005;
      5: return 32'h3A85_1BD7;
      6: return 32'h0000_74EA;
      7: return 32'hFFFF_FFFF;
      8: return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  // One's-complement sum of the IP address words, folded until no carry remains.
  function automatic logic [15:0] csum_model(logic [15:0] base, logic [31:0] lip, logic [31:0] rip);
    logic [31:0] s;
    s = 32'(base) + 32'(lip[31:16]) + 32'(lip[15:0]) + 32'(rip[31:16]) + 32'(rip[15:0]);
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  always @(posedge clk) exp_valid <= bus_if.read;

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) if (cfg_update_o[c]) upd_count[c]++;
    if (exp_valid || bus_if.readdatavalid) begin
      check_output("readdatavalid", 128'(bus_if.readdatavalid), 128'(exp_valid));
      if (bus_if.readdatavalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL readdata: got 0x%0h with no read outstanding", bus_if.readdata);
        end else begin
          check_output("readdata", 128'(bus_if.readdata), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic apply_stimulus(input vec_t v);
    bus_if.write      = v.wr;
    bus_if.read       = v.rd;
    bus_if.address    = {v.ch, v.idx};
    bus_if.writedata  = v.wdata;
    bus_if.byteenable = v.be;
    if (v.rd) exp_q.push_back(v.exp_rd);
    @(posedge clk);
    #1;
    bus_if.write = 1'b0;
    bus_if.read  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_checksum"},    128'(checksum_o),    128'({NUM_CH{16'hF957}}));
    check_output({pfx, "_local_port"},  128'(local_port_o),  128'({NUM_CH{16'hAAAA}}));
    check_output({pfx, "_remote_port"}, 128'(remote_port_o), 128'({NUM_CH{16'hFDE2}}));
    check_output({pfx, "_local_ip"},    128'(local_ip_o),    128'({NUM_CH{32'hC0A80004}}));
    check_output({pfx, "_remote_ip"},   128'(remote_ip_o),   128'({NUM_CH{32'hC0A80005}}));
    check_output({pfx, "_local_mac"},   128'(local_mac_o),   128'({NUM_CH{48'h74EA3A851BD7}}));
    check_output({pfx, "_remote_mac"},  128'(remote_mac_o),  128'({NUM_CH{48'hFFFFFFFFFFFF}}));
    check_output({pfx, "_cfg_update"},  128'(cfg_update_o),  128'(0));
    check_output({pfx, "_busy"},        128'(busy_o),        128'(0));
  endtask

  // Returns at the negedge where the channel's update pulse is seen (lat = 0 on timeout).
  task automatic wait_update(input int ch, output int lat, output int busy_cnt, output bit early);
    logic [NUM_CH*32-1:0] snap;
    snap = local_ip_o;
    lat = 0; busy_cnt = 0; early = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy_o[ch]) busy_cnt++;
      if (cfg_update_o[ch]) begin
        lat = k;
        break;
      end
      if (local_ip_o !== snap) early = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [$];
    int          lat, bc;
    bit          early;
    int          upd_snap [NUM_CH];
    logic [15:0] exp_cs0, exp_cs1;

    bus_if.write = 1'b0; bus_if.read = 1'b0; bus_if.address = '0;
    bus_if.writedata = '0; bus_if.byteenable = '0;
    exp_cs1 = AUTO ? csum_model(16'h0000, 32'hC0A80001, 32'hC0A80005) : 16'hF957;
    exp_cs0 = AUTO ? csum_model(16'h0000, 32'hC0A80004, 32'hC0A80005) : 16'hF957;

    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++)
        vecs.push_back(mk(0, 1, 3'(c), 4'(i), 0, 4'h0, rst_reg(i)));
    vecs.push_back(mk(1, 0, 3'd1, 4'd3,  32'h0A000001, 4'b0011, 0));
    vecs.push_back(mk(0, 1, 3'd1, 4'd3,  0, 4'h0, 32'hC0A80001));
    vecs.push_back(mk(1, 1, 3'd0, 4'd1,  32'h12345678, 4'hF, 32'h0000AAAA));
    vecs.push_back(mk(0, 1, 3'd0, 4'd1,  0, 4'h0, 32'h12345678));
    vecs.push_back(mk(1, 0, 3'd0, 4'd2,  32'hDEADBEEF, 4'b1100, 0));
    vecs.push_back(mk(0, 1, 3'd0, 4'd2,  0, 4'h0, 32'hDEADFDE2));
    vecs.push_back(mk(1, 0, 3'd7, 4'd1,  32'hFFFFFFFF, 4'hF, 0));
    vecs.push_back(mk(0, 1, 3'd7, 4'd1,  0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd7, 4'd10, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd1, 4'd1,  0, 4'h0, 32'h0000AAAA));
    vecs.push_back(mk(0, 1, 3'd0, 4'd9,  0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd0, 4'd12, 32'hFFFFFFFF, 4'hF, 0));
    vecs.push_back(mk(0, 1, 3'd0, 4'd12, 0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 1, 3'd0, 4'd10, 0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 0, 3'd0, 4'd9,  32'h0, 4'hF, 0));
    vecs.push_back(mk(1, 0, 3'd1, 4'd9,  32'h1, 4'b1110, 0));
    vecs.push_back(mk(0, 1, 3'd0, 4'd5,  0, 4'h0, 32'h3A851BD7));

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_output("reset_readdata", 128'(bus_if.readdata), 128'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] vector table: %0d entries", vecs.size());
    foreach (vecs[n]) apply_stimulus(vecs[n]);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_output("table_no_update_ch0", 128'(upd_count[0]), 128'(0));
    check_output("table_no_update_ch1", 128'(upd_count[1]), 128'(0));
    check_output("table_local_ip_held", 128'(local_ip_o), 128'({NUM_CH{32'hC0A80004}}));
    check_output("table_local_port_held", 128'(local_port_o), 128'({NUM_CH{16'hAAAA}}));

    $display("[TB] commit ch1");
    apply_stimulus(mk(1, 0, 3'd1, 4'd9, 32'h1, 4'h1, 0));
    wait_update(1, lat, bc, early);
    check_output("ch1_latency", 128'(lat), 128'(AUTO ? 8 : 1));
    check_output("ch1_busy_cycles", 128'(bc), 128'(AUTO ? 7 : 0));
    check_output("ch1_early_change", 128'(early), 128'(0));
    check_output("ch1_cfg_update", 128'(cfg_update_o), 128'(2'b10));
    check_output("ch1_local_ip", 128'(local_ip_o), 128'({32'hC0A80001, 32'hC0A80004}));
    check_output("ch1_checksum", 128'(checksum_o), 128'({exp_cs1, 16'hF957}));
    @(negedge clk);
    check_output("ch1_update_one_cycle", 128'(cfg_update_o), 128'(0));
    @(posedge clk);
    #1;

    $display("[TB] commit ch0");
    apply_stimulus(mk(1, 0, 3'd0, 4'd9, 32'h1, 4'h1, 0));
    wait_update(0, lat, bc, early);
    check_output("ch0_latency", 128'(lat), 128'(AUTO ? 8 : 1));
    check_output("ch0_busy_cycles", 128'(bc), 128'(AUTO ? 7 : 0));
    check_output("ch0_cfg_update", 128'(cfg_update_o), 128'(2'b01));
    check_output("ch0_checksum", 128'(checksum_o), 128'({exp_cs1, exp_cs0}));
    check_output("ch0_local_port", 128'(local_port_o), 128'({16'hAAAA, 16'h5678}));
    check_output("ch0_remote_port", 128'(remote_port_o), 128'({16'hFDE2, 16'hFDE2}));
    @(posedge clk);
    #1;

    $display("[TB] commit while busy");
    apply_stimulus(mk(1, 0, 3'd0, 4'd9, 32'h1, 4'hF, 0));
    apply_stimulus(mk(1, 0, 3'd0, 4'd9, 32'h1, 4'hF, 0));
    apply_stimulus(mk(0, 1, 3'd0, 4'd10, 0, 4'h0, AUTO ? 32'h3 : 32'h0));
    repeat (10) @(posedge clk);
    #1;
    apply_stimulus(mk(0, 1, 3'd0, 4'd10, 0, 4'h0, 32'h0));
    check_output("recommit_busy_idle", 128'(busy_o), 128'(0));

    $display("[TB] two channels together");
    upd_snap = upd_count;
    apply_stimulus(mk(1, 0, 3'd0, 4'd9, 32'h1, 4'h1, 0));
    apply_stimulus(mk(1, 0, 3'd1, 4'd9, 32'h1, 4'h1, 0));
    @(negedge clk);
    check_output("dual_busy", 128'(busy_o), 128'(AUTO ? 2'b11 : 2'b00));
    repeat (12) @(posedge clk);
    #1;
    check_output("dual_update_ch0", 128'(upd_count[0] - upd_snap[0]), 128'(1));
    check_output("dual_update_ch1", 128'(upd_count[1] - upd_snap[1]), 128'(1));

    $display("[TB] reset during computation");
    apply_stimulus(mk(1, 0, 3'd0, 4'd3, 32'h01020304, 4'hF, 0));
    apply_stimulus(mk(1, 0, 3'd0, 4'd9, 32'h1, 4'h1, 0));
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    upd_snap = upd_count;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("midreset_no_update_ch0", 128'(upd_count[0] - upd_snap[0]), 128'(0));
    check_reset_outputs("postreset");
    apply_stimulus(mk(0, 1, 3'd0, 4'd3, 0, 4'h0, 32'hC0A80004));
    apply_stimulus(mk(0, 1, 3'd0, 4'd10, 0, 4'h0, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_cfg_regs_mc.md
Name: eth_cfg_regs_mc

Overview:
- Multi-channel, double-buffered Avalon-MM configuration register bank for the UDP/IP/Ethernet transmit path.
- Software writes a per-channel shadow set, then commits it; the active set driving the packet builder updates atomically on commit.
- Optionally computes the IP-header partial checksum in hardware on commit, instead of taking the value software wrote.

Parameters:
- NUM_CH, 2, number of independent UDP channels (1..8).
- CH_W, 3, channel-select address bits; must satisfy 2**CH_W >= NUM_CH.
- CSUM_BASE, 16'h0000, constant 16-bit word pre-loaded into the checksum accumulator (covers the fixed IP-header fields).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  CH_W+4  bits [3:0] = register index; bits [CH_W+3:4] = channel.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write.
- readdata  out  32  read data, registered.
- readdatavalid  out  1  high for 1 cycle, 1 cycle after an accepted read.
- checksum_o  out  NUM_CH*16  active checksum per channel; channel c is at [16c+15:16c].
- local_port_o / remote_port_o  out  NUM_CH*16  active UDP ports.
- local_ip_o / remote_ip_o  out  NUM_CH*32  active IPv4 addresses.
- local_mac_o / remote_mac_o  out  NUM_CH*48  active MAC addresses, {MSB[15:0], LSB[31:0]}.
- cfg_update_o  out  NUM_CH  1-cycle pulse when a channel's active set changes.
- busy_o  out  NUM_CH  channel checksum engine running.

Behaviour:
- Register map per channel (index):
  - 0 checksum, 1 local_port, 2 remote_port, 3 local_IP, 4 remote_IP
  - 5 local_MAC_LSB, 6 local_MAC_MSB, 7 remote_MAC_LSB, 8 remote_MAC_MSB
  - 9 COMMIT (write-only; reads return 0)
  - 10 STATUS, read-only: bit0 = busy, bit1 = sticky commit error
  - 11..15 reserved: reads return 0, writes ignored.
- Writes to indices 0..8 update the shadow register, byte lanes gated by byteenable. Active registers are never written directly.
- Reads of indices 0..8 return the shadow value.
- Channel field >= NUM_CH: writes ignored, reads return 0.
- readdata is updated only on an accepted read and holds its value otherwise.
- A read and a write in the same cycle: the read returns the pre-write value.
- Commit is accepted when writedata[0]=1 and byteenable[0]=1 on a write to index 9.
- Commit without auto checksum (see Optional Feature): at the accepting edge, all active regs of that channel take the shadow values. cfg_update_o[c] is high during the following cycle, aligned with the new outputs.
- Commit with auto checksum: per-channel FSM IDLE -> ACC0..ACC3 -> FOLD1 -> FOLD2 -> DONE -> IDLE.
  - The commit edge snapshots the shadow set into staging and enters ACC0.
  - The 20-bit accumulator starts at CSUM_BASE. ACC0..3 add local_IP[31:16], local_IP[15:0], remote_IP[31:16], remote_IP[15:0], one word per cycle.
  - FOLD1 and FOLD2 each compute acc = acc[15:0] + acc[19:16].
  - DONE loads active <= staging, with checksum = ~acc[15:0], and pulses cfg_update_o[c].
  - busy_o[c] is high from the cycle after commit through DONE: 7 cycles.
  - Active outputs keep their old values until DONE.
- Commit to a channel while busy_o[c]=1: ignored, STATUS bit1 set.
- Reading STATUS returns the current value, then clears bit1 on the same edge. A new error in that same cycle wins, so bit1 stays set.
- Channels are independent; simultaneous busy channels are allowed.
- Reset values, all channels, shadow and active identical:
  - checksum 0x0000F957
  - local_port 0x0000AAAA, remote_port 0x0000FDE2
  - local_IP 0xC0A80004, remote_IP 0xC0A80005
  - local_MAC 0x74EA3A851BD7, remote_MAC 0xFFFFFFFFFFFF
  - readdata 0; readdatavalid, cfg_update_o, busy_o, STATUS all 0; FSMs in IDLE.
- Reset mid-computation aborts the FSM and restores all reset values. No cfg_update_o pulse is issued.

Optional Feature:
- Macro ETH_CFG_AUTO_CSUM_EN.
- Defined: checksum engine present; index 0 writes still update the shadow register, but the active checksum always comes from the engine.
- Undefined: no engine; the active checksum is copied from shadow index 0 on commit; busy_o is tied 0; STATUS bit1 is never set.

Test Plan:
- Reset, then read ch0 and ch1 indices 0..8 -> reset values, each with readdatavalid 1 cycle after read; outputs match reset values.
- Write ch1 index 3 = 0x0A000001 with byteenable=4'b0011, then read -> 0xC0A80001; local_ip_o ch1 unchanged until commit; cfg_update_o[1] pulses after commit; ch0 outputs unchanged.
- AUTO: CSUM_BASE=0, commit ch0 with reset IPs -> busy_o[0] high for 7 cycles, checksum_o[15:0]=0x7EA5 at DONE, coincident with the cfg_update_o[0] pulse.
- AUTO: re-commit ch0 during busy -> ignored, STATUS=0x3; second STATUS read after DONE -> 0x0.
- Write/read channel 7 with NUM_CH=2 -> no state change, read returns 0; indices 9 and 12 read 0.
- Assert reset_n low during ACC2 -> outputs return to reset values, no cfg_update_o pulse, busy_o=0.
